// File: rtl/tcm_mem_loader.sv
// Byte-stream to 64-bit word packer that drives the TCM write port.
// Optional byte checksum is enabled with the TCM_LOADER_CSUM_EN macro.
module tcm_mem_loader #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_data_o,
  output logic [7:0]        mem_wstrb_o,
  input  logic              mem_accept_i,
  output logic [15:0]       csum_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  remaining_r;
  logic [2:0]        lane_r;
  logic [63:0]       data_r;
  logic [7:0]        strb_r;
  logic              err_r;
  logic              busy_r;
  logic              done_r;
  logic              ready_r;
  logic              wr_r;

  logic              start_acc_s;
  logic              byte_acc_s;
  logic              wr_acc_s;
  logic              last_byte_s;
  logic              len_zero_s;
  logic              addr_top_s;

  assign start_acc_s = (state_r == ST_IDLE) && start_i;
  assign byte_acc_s  = (state_r == ST_FILL) && in_valid_i;
  assign wr_acc_s    = (state_r == ST_WRITE) && mem_accept_i;
  assign len_zero_s  = (len_i == {LEN_W{1'b0}});
  assign addr_top_s  = (addr_r == {ADDR_W{1'b1}});
  // A word closes when its top lane fills or the load runs out of bytes.
  assign last_byte_s = (lane_r == 3'd7) || (remaining_r == LEN_W'(1'b1));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_zero_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (in_valid_i && last_byte_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_WRITE: begin
        if (mem_accept_i) begin
          if (remaining_r == {LEN_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they track state_r exactly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      ready_r <= (state_nxt_s == ST_FILL);
      wr_r    <= (state_nxt_s == ST_WRITE);
    end
  end

  // Word packing, address stepping and wrap error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      lane_r      <= 3'd0;
      data_r      <= 64'h0;
      strb_r      <= 8'h00;
      err_r       <= 1'b0;
    end else if (start_acc_s) begin
      addr_r      <= base_addr_i;
      remaining_r <= len_i;
      lane_r      <= 3'd0;
      data_r      <= 64'h0;
      strb_r      <= 8'h00;
      err_r       <= 1'b0;
    end else if (byte_acc_s) begin
      data_r[{lane_r, 3'b000} +: 8] <= in_data_i;
      strb_r[lane_r]                <= 1'b1;
      lane_r                        <= lane_r + 3'd1;
      remaining_r                   <= remaining_r - LEN_W'(1'b1);
    end else if (wr_acc_s) begin
      addr_r <= addr_r + ADDR_W'(1'b1);
      lane_r <= 3'd0;
      data_r <= 64'h0;
      strb_r <= 8'h00;
      // Wrapping with bytes still pending is flagged but the load carries on.
      if (addr_top_s && (remaining_r != {LEN_W{1'b0}})) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end else begin
      err_r <= err_r;
    end
  end

`ifdef TCM_LOADER_CSUM_EN
  logic [15:0] csum_r;

  // Wrapping sum of accepted bytes, held after the load completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_r <= 16'h0000;
    end else if (start_acc_s) begin
      csum_r <= 16'h0000;
    end else if (byte_acc_s) begin
      csum_r <= csum_r + {8'h00, in_data_i};
    end else begin
      csum_r <= csum_r;
    end
  end

  assign csum_o = csum_r;
`else
  assign csum_o = 16'h0000;
`endif

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign in_ready_o  = ready_r;
  assign mem_wr_o    = wr_r;
  assign mem_addr_o  = addr_r;
  assign mem_data_o  = data_r;
  assign mem_wstrb_o = strb_r;

endmodule

// File: tb/tb_tcm_mem_loader.sv
// Self-checking bench for tcm_mem_loader: directed loads plus randomized
// loads compared against a word-level reference model.
module tb_tcm_mem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [12:0] base_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic        mem_wr_o;
  logic [12:0] mem_addr_o;
  logic [63:0] mem_data_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_accept_i;
  logic [15:0] csum_o;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned stim_q[$];
  logic [12:0]  exp_addr_q[$];
  logic [63:0]  exp_data_q[$];
  logic [7:0]   exp_strb_q[$];
  logic [12:0]  obs_addr_q[$];
  logic [63:0]  obs_data_q[$];
  logic [7:0]   obs_strb_q[$];
  logic         exp_err;
  logic [15:0]  exp_csum;

  tcm_mem_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_accept_i (mem_accept_i),
    .csum_o       (csum_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int len);
    stim_q.delete();
    for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
  endtask

  // Reference: slice the byte list into 8-byte words at consecutive addresses.
  task automatic build_model(input logic [12:0] base, input int len);
    int nwords;
    nwords = (len + 7) / 8;
    exp_addr_q.delete(); exp_data_q.delete(); exp_strb_q.delete();
    exp_err  = 1'b0;
    exp_csum = 16'h0000;
    for (int w = 0; w < nwords; w++) begin
      logic [63:0] d;
      logic [7:0]  s;
      logic [12:0] a;
      d = 64'h0; s = 8'h00;
      a = 13'(int'(base) + w);
      for (int l = 0; l < 8; l++) begin
        if (w * 8 + l < len) begin
          d[l*8 +: 8] = stim_q[w*8+l];
          s[l] = 1'b1;
        end
      end
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
      exp_strb_q.push_back(s);
      if (w < nwords - 1 && a == 13'h1FFF) exp_err = 1'b1;
    end
`ifdef TCM_LOADER_CSUM_EN
    for (int i = 0; i < len; i++) exp_csum = exp_csum + 16'(stim_q[i]);
`endif
  endtask

  // hold < 0: random accept delay 0..2 cycles; otherwise fixed delay per write.
  task automatic run_load(input string name, input logic [12:0] base, input int len,
                          input int hold, input bit noise);
    int  idx, cyc, held, hold_tgt;
    bit  acc_pend, done_seen, boundary;
    logic [12:0] snap_a;
    logic [63:0] snap_d;
    logic [7:0]  snap_s;
    build_model(base, len);
    obs_addr_q.delete(); obs_data_q.delete(); obs_strb_q.delete();
    @(negedge clk_i);
    chk({name, "_idle"}, 64'(busy_o), 64'(1'b0));
    start_i = 1'b1; base_addr_i = base; len_i = 16'(len);
    @(negedge clk_i);
    start_i = 1'b0; base_addr_i = 13'($urandom); len_i = 16'($urandom);
    chk({name, "_busy"}, 64'(busy_o), 64'(1'b1));
    idx = 0; cyc = 0; held = 0; acc_pend = 1'b0; done_seen = 1'b0;
    hold_tgt = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
    snap_a = '0; snap_d = '0; snap_s = '0;
    while (!done_seen && cyc < 3000) begin
      if (acc_pend) begin
        idx++;
        boundary = (idx % 8 == 0) || (idx == len);
        chk({name, "_wr_after_byte"}, 64'(mem_wr_o), 64'(boundary));
        chk({name, "_ready_after_byte"}, 64'(in_ready_o), 64'(!boundary));
      end
      acc_pend = 1'b0;
      start_i  = 1'b0;
      if (done_o) begin
        done_seen = 1'b1;
        in_valid_i = 1'b0; mem_accept_i = 1'b0;
      end else begin
        if (mem_wr_o) begin
          chk({name, "_ready_in_write"}, 64'(in_ready_o), 64'(1'b0));
          if (held > 0) begin
            chk({name, "_hold_addr"}, 64'(mem_addr_o), 64'(snap_a));
            chk({name, "_hold_data"}, mem_data_o, snap_d);
            chk({name, "_hold_strb"}, 64'(mem_wstrb_o), 64'(snap_s));
          end
          snap_a = mem_addr_o; snap_d = mem_data_o; snap_s = mem_wstrb_o;
          if (held < hold_tgt) begin
            mem_accept_i = 1'b0;
            held++;
          end else begin
            mem_accept_i = 1'b1;
            obs_addr_q.push_back(mem_addr_o);
            obs_data_q.push_back(mem_data_o);
            obs_strb_q.push_back(mem_wstrb_o);
            held = 0;
            hold_tgt = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
          end
        end else begin
          mem_accept_i = 1'($urandom_range(0, 1));
        end
        in_valid_i = (idx < len) && ($urandom_range(0, 3) != 0);
        in_data_i  = (idx < len) ? stim_q[idx] : 8'($urandom);
        acc_pend   = in_valid_i && in_ready_o;
        if (noise && busy_o && $urandom_range(0, 5) == 0) begin
          start_i = 1'b1; base_addr_i = 13'($urandom); len_i = 16'($urandom_range(1, 9));
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    start_i = 1'b0;
    chk({name, "_done_seen"}, 64'(done_seen), 64'(1'b1));
    if (len == 0) chk({name, "_len0_latency"}, 64'(cyc), 64'(0));
    chk({name, "_bytes_used"}, 64'(idx), 64'(len));
    chk({name, "_err"}, 64'(err_o), 64'(exp_err));
    chk({name, "_csum"}, 64'(csum_o), 64'(exp_csum));
    chk({name, "_n_writes"}, 64'(obs_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      chk({name, "_addr"}, 64'(obs_addr_q[i]), 64'(exp_addr_q[i]));
      chk({name, "_data"}, obs_data_q[i], exp_data_q[i]);
      chk({name, "_strb"}, 64'(obs_strb_q[i]), 64'(exp_strb_q[i]));
    end
    @(negedge clk_i);
    chk({name, "_done_pulse"}, 64'(done_o), 64'(1'b0));
    chk({name, "_idle_after"}, 64'(busy_o), 64'(1'b0));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"},  64'(busy_o),      64'(1'b0));
    chk({name, "_done"},  64'(done_o),      64'(1'b0));
    chk({name, "_err"},   64'(err_o),       64'(1'b0));
    chk({name, "_ready"}, 64'(in_ready_o),  64'(1'b0));
    chk({name, "_wr"},    64'(mem_wr_o),    64'(1'b0));
    chk({name, "_addr"},  64'(mem_addr_o),  64'(13'h0));
    chk({name, "_data"},  mem_data_o,       64'h0);
    chk({name, "_strb"},  64'(mem_wstrb_o), 64'(8'h00));
    chk({name, "_csum"},  64'(csum_o),      64'(16'h0000));
  endtask

  initial begin
    int wr_seen;
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = 13'h0; len_i = 16'h0;
    in_valid_i = 1'b0; in_data_i = 8'h00; mem_accept_i = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'(i));
    run_load("t1", 13'h010, 16, -1, 1'b0);
    chk("t1_word0", obs_data_q[0], 64'h0706050403020100);
    chk("t1_word1", obs_data_q[1], 64'h0F0E0D0C0B0A0908);
`ifdef TCM_LOADER_CSUM_EN
    chk("t1_csum_const", 64'(csum_o), 64'(16'h0078));
`endif

    stim_q.delete();
    stim_q.push_back(8'hAA); stim_q.push_back(8'hBB); stim_q.push_back(8'hCC);
    run_load("t2", 13'h005, 3, 0, 1'b0);
    chk("t2_word", obs_data_q[0], 64'h0000000000CCBBAA);
    chk("t2_strb", 64'(obs_strb_q[0]), 64'(8'h07));

    fill_random(8);
    run_load("t3", 13'h123, 8, 5, 1'b0);

    fill_random(16);
    run_load("t4", 13'h1FFF, 16, -1, 1'b0);
    chk("t4_wrap_addr", 64'(obs_addr_q[1]), 64'(13'h0000));
    chk("t4_err_set", 64'(err_o), 64'(1'b1));

    stim_q.delete();
    run_load("t5_len0", 13'h040, 0, -1, 1'b0);
    fill_random(20);
    run_load("t5_noise", 13'h0A0, 20, -1, 1'b1);

    // Reset in the middle of a load after four bytes.
    fill_random(8);
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = 13'h100; len_i = 16'd8;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1; in_data_i = stim_q[k];
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    chk("t6_still_fill", 64'(in_ready_o), 64'(1'b1));
    chk("t6_no_wr_yet", 64'(mem_wr_o), 64'(1'b0));
    rst_i = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    in_valid_i = 1'b1; mem_accept_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (mem_wr_o || busy_o) wr_seen++;
    end
    chk("t6_no_activity", 64'(wr_seen), 64'(0));
    in_valid_i = 1'b0; mem_accept_i = 1'b0;

    for (int r = 0; r < 8; r++) begin
      int rl;
      logic [12:0] rb;
      rl = int'($urandom_range(1, 40));
      rb = (r == 3) ? 13'(13'h1FFC + $urandom_range(0, 3)) : 13'($urandom);
      fill_random(rl);
      run_load("rnd", rb, rl, (r % 2 == 0) ? -1 : int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
